// File: rtl/aes_pkg.sv
// Shared AES definitions for the encipher and decipher datapaths:
// key-length encodings, round counts, the iterative FSM state encoding and
// the GF(2^8) column/row helpers. No ports; imported by the rtl modules.
package aes_pkg;

  localparam logic [1:0] KEYLEN_128 = 2'b00;
  localparam logic [1:0] KEYLEN_256 = 2'b01;
  localparam logic [1:0] KEYLEN_192 = 2'b10;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_SBOX = 2'd2,
    ST_MAIN = 2'd3
  } aes_fsm_e;

  // 2'b11 is not a defined key length and runs as AES-256.
  function automatic logic [3:0] num_rounds(input logic [1:0] keylen);
    case (keylen)
      KEYLEN_128: return NR_128;
      KEYLEN_192: return NR_192;
      default:    return NR_256;
    endcase
  endfunction

  function automatic logic [7:0] gm2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm3(input logic [7:0] b);
    return gm2(b) ^ b;
  endfunction

  function automatic logic [31:0] mixw(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    {b0, b1, b2, b3} = w;
    return {gm2(b0) ^ gm3(b1) ^ b2 ^ b3,
            b0 ^ gm2(b1) ^ gm3(b2) ^ b3,
            b0 ^ b1 ^ gm2(b2) ^ gm3(b3),
            gm3(b0) ^ b1 ^ b2 ^ gm2(b3)};
  endfunction

  function automatic logic [127:0] mixcolumns(input logic [127:0] s);
    return {mixw(s[127:96]), mixw(s[95:64]), mixw(s[63:32]), mixw(s[31:0])};
  endfunction

  // Column-major state: byte 4*c+r sits at bits 127-8*(4*c+r).
  function automatic logic [127:0] shiftrows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_encipher_block_if.sv
// Handshake/data bundle between the round-key memory / controller (master)
// and the encipher datapath (slave): start pulse, key length, round index,
// round key, plaintext in, cipher state out and ready.
interface aes_encipher_block_if;
  logic         next;
  logic [1:0]   keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;

  modport slave (
    input  next, keylen, round_key, block,
    output round, new_block, ready
  );

  modport master (
    output next, keylen, round_key, block,
    input  round, new_block, ready
  );
endinterface

// File: rtl/aes_sbox.sv
// Combinational forward S-box on one 32-bit word, four bytes in parallel.
// Ports: sword (input word), new_sword (substituted word).
// Each byte is computed as multiplicative inverse in GF(2^8) followed by
// the AES affine map, instead of a 256-entry table.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [31:0] sword,
  output logic [31:0] new_sword
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = gm2(x);
    end
    return p;
  endfunction

  // x^254 == x^-1 for x != 0, and 0 maps to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h01;
    p   = x;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      acc = gf_mul(acc, p);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sub_byte(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  assign new_sword = {sub_byte(sword[31:24]), sub_byte(sword[23:16]),
                      sub_byte(sword[15:8]),  sub_byte(sword[7:0])};

endmodule

// File: rtl/aes_encipher_block.sv
// Iterative AES encipher datapath, one S-box word per cycle.
// Ports: clk, reset (synchronous, active-high), bus (slave side of
// aes_encipher_block_if: next/keylen/block/round_key in, round/new_block/
// ready out). The round key is looked up externally from `round` and must
// be valid in the same cycle.
//
// state | meaning
// IDLE  | result held, ready=1, waits for next
// INIT  | initial AddRoundKey with round key 0
// SBOX  | SubWord on one 32-bit word per cycle, four cycles
// MAIN  | ShiftRows (+MixColumns except last round) and AddRoundKey
module aes_encipher_block
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  aes_encipher_block_if.slave bus
);

  aes_fsm_e     fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   round_ctr_q, round_ctr_d;
  logic [1:0]   sword_ctr_q, sword_ctr_d;
  logic         ready_q, ready_d;
  logic [1:0]   keylen_q, keylen_d;
  logic [31:0]  sbox_in, sbox_out;
  logic [127:0] shifted;

  always_comb begin
    case (sword_ctr_q)
      2'd0:    sbox_in = state_q[127:96];
      2'd1:    sbox_in = state_q[95:64];
      2'd2:    sbox_in = state_q[63:32];
      default: sbox_in = state_q[31:0];
    endcase
  end

  aes_sbox u_sbox (
    .sword     (sbox_in),
    .new_sword (sbox_out)
  );

  assign shifted = shiftrows(state_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q       <= ST_IDLE;
      state_q     <= '0;
      round_ctr_q <= '0;
      sword_ctr_q <= '0;
      ready_q     <= 1'b1;
      keylen_q    <= KEYLEN_128;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      round_ctr_q <= round_ctr_d;
      sword_ctr_q <= sword_ctr_d;
      ready_q     <= ready_d;
      keylen_q    <= keylen_d;
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    round_ctr_d = round_ctr_q;
    sword_ctr_d = sword_ctr_q;
    ready_d     = ready_q;
    keylen_d    = keylen_q;
    case (fsm_q)
      ST_IDLE: begin
        if (bus.next) begin
          round_ctr_d = '0;
          ready_d     = 1'b0;
          keylen_d    = bus.keylen;
          fsm_d       = ST_INIT;
        end
      end
      ST_INIT: begin
        state_d     = bus.block ^ bus.round_key;
        round_ctr_d = 4'd1;
        sword_ctr_d = '0;
        fsm_d       = ST_SBOX;
      end
      ST_SBOX: begin
        case (sword_ctr_q)
          2'd0:    state_d[127:96] = sbox_out;
          2'd1:    state_d[95:64]  = sbox_out;
          2'd2:    state_d[63:32]  = sbox_out;
          default: state_d[31:0]   = sbox_out;
        endcase
        sword_ctr_d = sword_ctr_q + 2'd1;
        if (sword_ctr_q == 2'd3) fsm_d = ST_MAIN;
      end
      default: begin
        if (round_ctr_q < num_rounds(keylen_q)) begin
          state_d     = mixcolumns(shifted) ^ bus.round_key;
          round_ctr_d = round_ctr_q + 4'd1;
          sword_ctr_d = '0;
          fsm_d       = ST_SBOX;
        end else begin
          // Final round: no MixColumns; round stays at Nr while idle.
          state_d = shifted ^ bus.round_key;
          ready_d = 1'b1;
          fsm_d   = ST_IDLE;
        end
      end
    endcase
  end

  assign bus.round     = round_ctr_q;
  assign bus.new_block = state_q;
  assign bus.ready     = ready_q;

endmodule

// File: tb/tb_aes_encipher_block.sv
// Self-checking bench for aes_encipher_block: known-answer vectors, held
// start pulse, mid-run reset, back-to-back runs and random keys/plaintexts
// compared against a byte-level AES model with its own key expansion.
module tb_aes_encipher_block;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_encipher_block_if bus();

  aes_encipher_block dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [127:0] rk_mem [15];
  logic [7:0]   sb [256];

  always_comb bus.round_key = (bus.round <= 4'd14) ? rk_mem[bus.round] : '0;

  typedef struct {
    logic [1:0]   kl;
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [3];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 0; x = a; y = b;
    while (y != 0) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // Generator walk: p runs over powers of 3, q over powers of 3^-1.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01; q = 8'h01;
    repeat (255) begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ ((q << 1) | (q >> 7)) ^ ((q << 2) | (q >> 6))
            ^ ((q << 3) | (q >> 5)) ^ ((q << 4) | (q >> 4));
      sb[p] = x ^ 8'h63;
    end
    sb[0] = 8'h63;
  endtask

  function automatic int nk_of(input logic [1:0] kl);
    return (kl == 2'b00) ? 4 : (kl == 2'b10) ? 6 : 8;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic set_keys(input logic [1:0] kl, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nr;
    nk = nk_of(kl); nr = nk + 6; rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 15; r++)
      rk_mem[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  function automatic logic [127:0] encrypt(input logic [1:0] kl, input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] res;
    int nr;
    nr = nk_of(kl) + 6;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk_mem[0][127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[4*c+row] = s[4*((c+row)%4)+row];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          s[4*c+row] = (r < nr) ? (gmul(t[4*c+row], 8'h02) ^ gmul(t[4*c+(row+1)%4], 8'h03)
                                   ^ t[4*c+(row+2)%4] ^ t[4*c+(row+3)%4])
                                : t[4*c+row];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk_mem[r][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Entered and left just after a falling edge, so calls chain back-to-back.
  task automatic run_cipher(input logic [1:0] kl, input logic [255:0] key, input logic [127:0] pt,
                            input logic [127:0] exp_ct, input bit hold_next, input string name);
    int nr, cyc;
    logic [3:0] seq [$];
    logic [3:0] last;
    bit ok;
    logic [127:0] ct;
    set_keys(kl, key);
    nr = nk_of(kl) + 6;
    bus.next = 1'b1; bus.keylen = kl; bus.block = pt;
    @(posedge clk);
    @(negedge clk);
    if (!hold_next) bus.next = 1'b0;
    bus.keylen = ~kl;
    seq.push_back(bus.round);
    last = bus.round;
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) bus.block = {$urandom, $urandom, $urandom, $urandom};
      if (bus.round != last) begin
        seq.push_back(bus.round);
        last = bus.round;
      end
      if (bus.ready) break;
    end
    check({name, "_latency"}, 128'(cyc), 128'(1 + 5*nr));
    check({name, "_ct"}, bus.new_block, exp_ct);
    ok = (seq.size() == nr + 1);
    for (int i = 0; i < seq.size(); i++) if (seq[i] != 4'(i)) ok = 1'b0;
    check({name, "_round_seq"}, 128'(ok), 128'(1));
    if (hold_next) begin
      bus.next = 1'b0;
      ct = bus.new_block;
      @(posedge clk);
      @(negedge clk);
      check({name, "_single_run_ready"}, 128'(bus.ready), 128'(1));
      check({name, "_single_run_hold"}, bus.new_block, ct);
    end
  endtask

  initial begin
    logic [127:0] hold_ct;
    logic [127:0] exp;
    logic [255:0] key;
    logic [127:0] pt;
    logic [1:0]   kl;
    int w;

    vecs[0] = '{2'b00, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{2'b10, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                128'h00112233445566778899aabbccddeeff, 128'hdda97ca4864cdfe06eaf70a0ec0d7191};
    vecs[2] = '{2'b01, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089};

    build_sbox();
    for (int r = 0; r < 15; r++) rk_mem[r] = '0;
    bus.next = 1'b0; bus.keylen = 2'b00; bus.block = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 128'(bus.ready), 128'(1));
    check("reset_new_block", bus.new_block, '0);
    check("reset_round", 128'(bus.round), 128'(0));
    reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      set_keys(vecs[i].kl, vecs[i].key);
      check($sformatf("model_kat%0d", i), encrypt(vecs[i].kl, vecs[i].pt), vecs[i].ct);
    end

    for (int i = 0; i < 3; i++)
      run_cipher(vecs[i].kl, vecs[i].key, vecs[i].pt, vecs[i].ct, 1'b0, $sformatf("kat%0d", i));

    run_cipher(vecs[0].kl, vecs[0].key, vecs[0].pt, vecs[0].ct, 1'b1, "held_next");

    hold_ct = bus.new_block;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("idle_hold_block", bus.new_block, hold_ct);
    check("idle_hold_ready", 128'(bus.ready), 128'(1));

    set_keys(vecs[2].kl, vecs[2].key);
    bus.next = 1'b1; bus.keylen = vecs[2].kl; bus.block = vecs[2].pt;
    @(posedge clk);
    @(negedge clk);
    bus.next = 1'b0;
    w = 0;
    while (bus.round != 4'd5 && w < 100) begin
      @(posedge clk);
      @(negedge clk);
      w++;
    end
    check("reach_round5", 128'(w < 100), 128'(1));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("midrun_reset_ready", 128'(bus.ready), 128'(1));
    check("midrun_reset_block", bus.new_block, '0);
    check("midrun_reset_round", 128'(bus.round), 128'(0));
    run_cipher(vecs[2].kl, vecs[2].key, vecs[2].pt, vecs[2].ct, 1'b0, "after_reset");

    for (int n = 0; n < 6; n++) begin
      kl = 2'($urandom_range(0, 3));
      for (int i = 0; i < 8; i++) key[32*i +: 32] = $urandom;
      for (int i = 0; i < 4; i++) pt[32*i +: 32] = $urandom;
      set_keys(kl, key);
      exp = encrypt(kl, pt);
      run_cipher(kl, key, pt, exp, 1'b0, $sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
